icache_fetch: RTL
=================

Name: icache_fetch

Overview:
- Instruction-side responder for the PC register: takes the fetch address, returns the instruction word, and drives the PC's stall input.
- Direct-mapped, read-only instruction cache with a word-serial refill FSM toward backing instruction memory.
- Sits between the PC/IF stage and instruction memory.
- On a hit, the instruction is returned combinationally in the same cycle; on a miss, the PC is stalled until the line is filled.

Parameters:
- LINES, 16, number of cache lines; power of two, at least 2.
- WORDS, 4, 32-bit words per line; power of two, at least 2.

Ports:
- clk_i  in  1  clock; rising-edge.
- rst_i  in  1  reset; asynchronous, active-low.
- start_i  in  1  fetch enable; when 0, no lookup, no miss, no refill start.
- pc_i  in  32  fetch byte address from the PC; bits [1:0] ignored.
- flush_i  in  1  invalidate all lines; sampled on the clock edge.
- instr_o  out  32  instruction word; valid when start_i=1 and stall_o=0.
- stall_o  out  1  high stalls the PC (PC holds its value).
- mem_req_o  out  1  word read request to instruction memory.
- mem_addr_o  out  32  word-aligned request address.
- mem_ack_i  in  1  memory accepted the request; mem_data_i is valid this cycle.
- mem_data_i  in  32  returned word.

Behaviour:
- Address split: offset = pc_i[2+log2(WORDS)-1:2]; index = next log2(LINES) bits; tag = remaining upper bits.
- Storage: per line, one valid bit, one tag and WORDS data words.
  - Only the valid bits need reset.
  - Data and tag arrays need no reset.
- Reset (rst_i=0, asynchronous):
  - All valid bits cleared; state = IDLE.
  - mem_req_o=0 and mem_addr_o=0.
  - Any refill in progress is aborted; a later mem_ack_i is ignored.
- Outputs while rst_i=0: stall_o=0 and instr_o=0.
- hit = start_i & valid[index] & (tag_store[index]==tag).
- IDLE:
  - hit: instr_o = data[index][offset], stall_o=0, combinational (zero latency).
  - start_i=1 and miss: stall_o=1 and instr_o=32'h0 in the same cycle. At the next edge, latch the line base address (pc_i with offset and byte bits zeroed), set beat=0 and go to REFILL.
  - start_i=0: stall_o=0 and instr_o=32'h0.
- REFILL:
  - stall_o=1, instr_o=32'h0, mem_req_o=1, mem_addr_o = base + 4*beat.
  - Request and address stay stable until mem_ack_i=1 is sampled.
  - On an ack edge: write mem_data_i into data[index_latched][beat], then beat+1.
  - mem_req_o stays high between beats; there is no idle cycle between beats.
  - On the ack of beat WORDS-1: write tag and set valid, deassert mem_req_o, go to DONE.
  - Changes on pc_i are ignored; the refill always completes for the latched line.
- DONE (one cycle):
  - stall_o=1, mem_req_o=0; go to IDLE.
  - The lookup then uses the current pc_i, which may miss again.
- Miss-to-hit cost: 1 (IDLE miss) + sum of beat cycles + 1 (DONE), then hit in IDLE.
  - With mem_ack_i tied high and WORDS=4: 6 stall cycles.
- mem_ack_i with mem_req_o=0 is ignored.
- flush_i=1 at an edge:
  - All valid bits cleared; state goes to IDLE; mem_req_o=0 from that edge.
  - A pending refill is abandoned and its line is not validated.
  - flush_i has priority over a simultaneous last-beat ack.
- A line refill overwrites whatever was in that index (conflict eviction); there is no replacement choice.

Test Plan:
- Reset, start_i=1, pc_i=0x00, mem_ack_i tied 1 with memory word[n]=0x1000_0000+n:
  - stall_o=1 for 6 cycles; mem_addr_o sequence 0x0, 0x4, 0x8, 0xC.
  - Then instr_o=0x1000_0000, stall_o=0.
- After the previous scenario, pc_i steps 0x4, 0x8, 0xC: instr_o = 0x1000_0001, 0x1000_0002, 0x1000_0003, each in the same cycle, with stall_o=0 and mem_req_o=0.
- Conflict: fetch 0x100 (same index 0, tag 1) -> refill from 0x100; then fetch 0x0 -> misses and refills again.
- Slow memory, ack every 3rd cycle:
  - mem_req_o and mem_addr_o stay stable between acks.
  - Changing pc_i to 0x40 mid-refill does not change the fill addresses 0x0..0xC.
  - Then 0x40 misses and a new refill starts.
- flush_i pulsed during beat 2 of a refill: mem_req_o drops at the next edge; a late ack is ignored; re-fetch of 0x0 misses and refills.
- Asynchronous rst_i low mid-refill: mem_req_o=0 and stall_o=0 immediately; after release, start_i=0 holds stall_o=0 with no requests.

Source files
------------

// File: rtl/icache_fetch.sv
// Direct-mapped read-only instruction cache: zero-latency hit path, word-serial refill on miss.
// Hit: 0 cycles; miss: 1 + beats + 1 stall cycles; waits on mem_ack_i per beat, flush aborts refill.
module icache_fetch #(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] pc_i,
  input  logic        flush_i,
  output logic [31:0] instr_o,
  output logic        stall_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i
);

  localparam int OFFW = $clog2(WORDS);
  localparam int IDXW = $clog2(LINES);
  localparam int LW   = 30 - OFFW;
  localparam int TAGW = LW - IDXW;

  typedef enum logic [1:0] {IDLE, REFILL, DONE} state_t;

  state_t             state_q, state_d;
  logic [LINES-1:0]   valid_q, valid_d;
  logic [LW-1:0]      line_q, line_d;
  logic [OFFW-1:0]    beat_q, beat_d;

  logic [31:0]        data_mem [LINES*WORDS];
  logic [TAGW-1:0]    tag_mem  [LINES];

  logic               data_we, tag_we, hit, stall, req;
  logic [31:0]        instr;
  logic [OFFW-1:0]    pc_off;
  logic [IDXW-1:0]    pc_idx, fill_idx;
  logic [TAGW-1:0]    pc_tag;
  logic               unused_byte;

  assign pc_off      = pc_i[2 +: OFFW];
  assign pc_idx      = pc_i[2+OFFW +: IDXW];
  assign pc_tag      = pc_i[31 -: TAGW];
  assign fill_idx    = line_q[IDXW-1:0];
  assign unused_byte = ^pc_i[1:0];
  assign hit         = start_i & valid_q[pc_idx] & (tag_mem[pc_idx] == pc_tag);

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    line_d  = line_q;
    beat_d  = beat_q;
    data_we = 1'b0;
    tag_we  = 1'b0;
    stall   = 1'b0;
    req     = 1'b0;
    instr   = '0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (hit) begin
            instr = data_mem[{pc_idx, pc_off}];
          end else begin
            stall   = 1'b1;
            line_d  = pc_i[31:2+OFFW];
            beat_d  = '0;
            state_d = REFILL;
          end
        end
      end
      REFILL: begin
        stall = 1'b1;
        req   = 1'b1;
        if (mem_ack_i) begin
          data_we = 1'b1;
          beat_d  = beat_q + OFFW'(1);
          if (beat_q == OFFW'(WORDS-1)) begin
            tag_we            = 1'b1;
            valid_d[fill_idx] = 1'b1;
            state_d           = DONE;
          end
        end
      end
      DONE: begin
        stall   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Flush wins over everything, including the ack that would validate the line.
    if (flush_i) begin
      valid_d = '0;
      state_d = IDLE;
      data_we = 1'b0;
      tag_we  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      valid_q <= '0;
      line_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      line_q  <= line_d;
      beat_q  <= beat_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (data_we) data_mem[{fill_idx, beat_q}] <= mem_data_i;
    if (tag_we)  tag_mem[fill_idx]            <= line_q[LW-1 -: TAGW];
  end

  assign stall_o    = rst_i & stall;
  assign instr_o    = rst_i ? instr : '0;
  assign mem_req_o  = req;
  assign mem_addr_o = req ? {line_q, beat_q, 2'b00} : '0;

endmodule
